// File: rtl/carry_adder.sv
// rtl/carry_adder.sv - 6-bit registered add/subtract unit with one ripple-carry chain
// Decodes the opcode into P/Q/cin, ripples the sum, and registers result and C/V/Z/N flags.
module carry_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] instruction,
    input  logic [5:0] A,
    input  logic [5:0] B,
    output logic       out_valid,
    output logic [5:0] X,
    output logic       C,
    output logic       V,
    output logic       Z,
    output logic       N
);

    localparam logic [3:0] OP_ADD = 4'b1010;
    localparam logic [3:0] OP_SUB = 4'b1011;
    localparam logic [3:0] OP_INC = 4'b1100;
    localparam logic [3:0] OP_DEC = 4'b1101;
    localparam logic [3:0] OP_NEG = 4'b1110;

    logic [5:0] p;
    logic [5:0] q;
    logic       cin;
    logic       op_known;
    logic [6:0] cy;
    logic [5:0] sum;
    logic [5:0] x_next;
    logic       c_next;
    logic       v_next;

    always_comb begin
        p        = 6'd0;
        q        = 6'd0;
        cin      = 1'b0;
        op_known = 1'b1;
        case (instruction)
            OP_ADD: begin p = A;    q = B;       cin = 1'b0; end
            OP_SUB: begin p = A;    q = ~B;      cin = 1'b1; end
            OP_INC: begin p = A;    q = 6'd0;    cin = 1'b1; end
            OP_DEC: begin p = A;    q = 6'h3F;   cin = 1'b0; end
            OP_NEG: begin p = 6'd0; q = ~A;      cin = 1'b1; end
            default: op_known = 1'b0;
        endcase
    end

    // Single ripple chain shared by every opcode; subtraction is add of ~operand plus one.
    always_comb begin
        cy    = 7'd0;
        sum   = 6'd0;
        cy[0] = cin;
        for (int i = 0; i < 6; i++) begin
            sum[i]  = p[i] ^ q[i] ^ cy[i];
            cy[i+1] = (p[i] & q[i]) | (p[i] & cy[i]) | (q[i] & cy[i]);
        end
    end

    always_comb begin
        x_next = 6'd0;
        c_next = 1'b0;
        v_next = 1'b0;
        if (op_known) begin
            x_next = sum;
            c_next = cy[6];
            v_next = (p[5] == q[5]) && (sum[5] != p[5]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            X         <= 6'd0;
            C         <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                X <= x_next;
                C <= c_next;
                V <= v_next;
                Z <= (x_next == 6'd0);
                N <= x_next[5];
            end
        end
    end

endmodule

// File: tb/tb_carry_adder.sv
// tb/tb_carry_adder.sv - directed self-checking bench for carry_adder
module tb_carry_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] instruction;
    logic [5:0] A;
    logic [5:0] B;
    logic       out_valid;
    logic [5:0] X;
    logic       C;
    logic       V;
    logic       Z;
    logic       N;

    int vectors;
    int miscompares;

    localparam logic [3:0] ADD = 4'b1010;
    localparam logic [3:0] SUB = 4'b1011;
    localparam logic [3:0] INC = 4'b1100;
    localparam logic [3:0] DEC = 4'b1101;
    localparam logic [3:0] NEG = 4'b1110;

    carry_adder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .X           (X),
        .C           (C),
        .V           (V),
        .Z           (Z),
        .N           (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [3:0] op, input logic [5:0] a, input logic [5:0] b, input logic vld);
        @(negedge clk);
        instruction = op;
        A           = a;
        B           = b;
        in_valid    = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [5:0] x,
                              input logic c, input logic v, input logic z, input logic n);
        vectors++;
        assert (out_valid === ov) else begin
            miscompares++;
            $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, ov);
        end
        assert (X === x) else begin
            miscompares++;
            $error("FAIL %s X: got %b expected %b", tag, X, x);
        end
        assert (C === c) else begin
            miscompares++;
            $error("FAIL %s C: got %b expected %b", tag, C, c);
        end
        assert (V === v) else begin
            miscompares++;
            $error("FAIL %s V: got %b expected %b", tag, V, v);
        end
        assert (Z === z) else begin
            miscompares++;
            $error("FAIL %s Z: got %b expected %b", tag, Z, z);
        end
        assert (N === n) else begin
            miscompares++;
            $error("FAIL %s N: got %b expected %b", tag, N, n);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 4'b0000;
        A           = 6'd0;
        B           = 6'd0;

        // Reset state, held across an edge with in_valid high
        #3;
        expect_out("reset", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        instruction = ADD;
        A = 6'd5;
        B = 6'd6;
        @(posedge clk);
        #1;
        expect_out("reset_hold", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed vectors, back-to-back
        step(SUB, 6'b000100, 6'b000001, 1'b1);
        expect_out("sub_4_1",     1'b1, 6'b000011, 1'b1, 1'b0, 1'b0, 1'b0);
        step(SUB, 6'b111001, 6'b000111, 1'b1);
        expect_out("sub_57_7",    1'b1, 6'b110010, 1'b1, 1'b0, 1'b0, 1'b1);
        step(ADD, 6'b011111, 6'b000001, 1'b1);
        expect_out("add_ovf",     1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(ADD, 6'b111111, 6'b000001, 1'b1);
        expect_out("add_wrap",    1'b1, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(INC, 6'b111111, 6'b010101, 1'b1);
        expect_out("inc_wrap",    1'b1, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(NEG, 6'b100000, 6'b000000, 1'b1);
        expect_out("neg_min",     1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(NEG, 6'b000000, 6'b111111, 1'b1);
        expect_out("neg_zero",    1'b1, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0);
        step(DEC, 6'b000000, 6'b000000, 1'b1);
        expect_out("dec_zero",    1'b1, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1);
        step(DEC, 6'b100000, 6'b000000, 1'b1);
        expect_out("dec_ovf",     1'b1, 6'b011111, 1'b1, 1'b1, 1'b0, 1'b0);
        step(SUB, 6'b000000, 6'b000001, 1'b1);
        expect_out("sub_borrow",  1'b1, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1);
        step(SUB, 6'b100000, 6'b000001, 1'b1);
        expect_out("sub_ovf",     1'b1, 6'b011111, 1'b1, 1'b1, 1'b0, 1'b0);
        step(ADD, 6'b010110, 6'b001101, 1'b1);
        expect_out("add_plain",   1'b1, 6'b100011, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4'b0000, 6'b101010, 6'b010101, 1'b1);
        expect_out("op_0000",     1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(ADD, 6'b000010, 6'b000011, 1'b1);
        expect_out("add_2_3",     1'b1, 6'b000101, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 6'b111111, 6'b111111, 1'b1);
        expect_out("op_1111",     1'b1, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Hold when in_valid drops
        step(ADD, 6'b011111, 6'b000001, 1'b1);
        expect_out("pre_hold",    1'b1, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(SUB, 6'b000000, 6'b000000, 1'b0);
        expect_out("hold_1",      1'b0, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(INC, 6'b000111, 6'b000000, 1'b0);
        expect_out("hold_2",      1'b0, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges, mid-stream
        step(DEC, 6'b000000, 6'b000000, 1'b1);
        expect_out("pre_rst",     1'b1, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst",   1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("rst_low_edge", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(SUB, 6'b000100, 6'b000001, 1'b1);
        expect_out("post_rst",    1'b1, 6'b000011, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        in_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
